// File: rtl/load_store_unit_if.sv
// Core request/response and data-RAM bus bundle for the load/store unit.
// The slave modport is the LSU view; master is the core+RAM side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_code;
  logic        mem_r_en;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_r_data;
  logic        mem_w_en;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [1:0]  mem_state;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_addr, req_wdata, mem_r_data, mem_state,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output resp_code, mem_r_en, mem_r_addr, mem_w_en,
    output mem_w_addr, mem_w_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_addr, req_wdata, mem_r_data, mem_state,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  resp_code, mem_r_en, mem_r_addr, mem_w_en,
    input  mem_w_addr, mem_w_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store initiator for a word-only single-port RAM.
// Sub-word stores use read-modify-write; loads are lane-extracted.
module load_store_unit #(
  parameter bit CHECK_ALIGNMENT = 1'b1,
  parameter bit SUBWORD_WRITE   = 1'b1
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD, RD_WAIT, WR, WR_WAIT,
    RMW_RD, RMW_WAIT, RMW_WR, RESP
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  code_q, code_d;

  logic        misaligned;
  logic        illegal;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [31:0] word_addr;

  assign word_addr = {addr_q[31:2], 2'b00};

  assign misaligned =
    (bus.req_size == 2'b01 && bus.req_addr[0]) ||
    (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  assign illegal =
    (bus.req_size == 2'b11) ||
    (CHECK_ALIGNMENT && misaligned) ||
    (!SUBWORD_WRITE && bus.req_we && !bus.req_size[1]);

  // Half lanes use addr[1] only, which also forces natural alignment
  assign lane_b = bus.mem_r_data[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = bus.mem_r_data[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = bus.mem_r_data;
    merged   = bus.mem_r_data;
    unique case (size_q)
      2'b00: begin
        load_val = {{24{~uns_q & lane_b[7]}}, lane_b};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{16{~uns_q & lane_h[15]}}, lane_h};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          data_d  = '0;
          code_d  = 2'b00;
          if (illegal) begin
            code_d  = 2'b11;
            state_d = RESP;
          end else if (!bus.req_we) begin
            state_d = RD;
          end else if (bus.req_size == 2'b10) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        code_d  = bus.mem_state;
        data_d  = (bus.mem_state == 2'b00) ? load_val : '0;
        state_d = RESP;
      end
      WR:      state_d = WR_WAIT;
      WR_WAIT: begin
        code_d  = bus.mem_state;
        data_d  = '0;
        state_d = RESP;
      end
      RMW_RD:  state_d = RMW_WAIT;
      RMW_WAIT: begin
        if (bus.mem_state != 2'b00) begin
          code_d  = bus.mem_state;
          data_d  = '0;
          state_d = RESP;
        end else begin
          data_d  = merged;
          state_d = RMW_WR;
        end
      end
      RMW_WR:  state_d = WR_WAIT;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      code_q  <= code_d;
    end
  end

  // Outputs decode from the async-reset state, so they drop with rst
  logic r_on, w_on, resp_on;
  assign r_on    = (state_q == RD) || (state_q == RMW_RD);
  assign w_on    = (state_q == WR) || (state_q == RMW_WR);
  assign resp_on = (state_q == RESP);

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_r_en   = r_on;
  assign bus.mem_r_addr = r_on ? word_addr : '0;
  assign bus.mem_w_en   = w_on;
  assign bus.mem_w_addr = w_on ? word_addr : '0;
  assign bus.mem_w_data = (state_q == WR)     ? wdata_q :
                          (state_q == RMW_WR) ? data_q  : '0;
  assign bus.resp_valid = resp_on;
  assign bus.resp_rdata = resp_on ? data_q : '0;
  assign bus.resp_code  = resp_on ? code_q : 2'b00;
  assign bus.resp_err   = resp_on && (code_q != 2'b00);

  logic unused;
  assign unused = we_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the word-only, single-port RAM: accepts byte, half and word load/store requests from the core and translates them into word-aligned RAM accesses.
- Sub-word stores are done by read-modify-write.
- Sub-word loads are lane-extracted and sign- or zero-extended.
- Checks natural alignment itself and forwards RAM error codes to the core.
- Sits between the core execute stage and the data RAM.

Parameters:
- CHECK_ALIGNMENT, 1, 1 = reject misaligned requests locally with code 2'b11. 0 = silently force the lane offset to natural alignment.
- SUBWORD_WRITE, 1, 1 = byte/half stores via RMW. 0 = sub-word stores rejected with code 2'b11.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (bits [7:0] / [15:0] / [31:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  response carries an error
- resp_code  out  2  00 ok, 01 read/write conflict, 10 out-of-bounds, 11 alignment/illegal
- mem_r_en  out  1  RAM read enable
- mem_r_addr  out  32  RAM read address, bits [1:0] always 0
- mem_r_data  in  32  RAM read data, valid the cycle after mem_r_en
- mem_w_en  out  1  RAM write enable
- mem_w_addr  out  32  RAM write address, bits [1:0] always 0
- mem_w_data  out  32  RAM write word
- mem_state  in  2  RAM status, valid the cycle after any enable

Behaviour:
- Reset values: req_ready=1, all other outputs 0, FSM in IDLE.
- Reset is asynchronous and may occur mid-operation:
  - strobes drop immediately; no response is produced for the aborted request;
  - an RMW whose write phase has not yet been issued leaves RAM unmodified.
- FSM states: IDLE, RD, RD_WAIT, WR, WR_WAIT, RMW_RD, RMW_WAIT, RMW_WR, RESP.
- Handshake:
  - req_ready=1 only in IDLE; a request is accepted on a clock edge with req_valid & req_ready high.
  - All request fields are latched on acceptance; the core may change its inputs afterwards.
- Illegal request = reserved size, or (CHECK_ALIGNMENT=1 and misaligned: half with addr[0]=1, word with addr[1:0]≠0), or (SUBWORD_WRITE=0 and a sub-word store).
  - Goes straight to RESP with code 11.
  - No RAM strobe is asserted.
  - Cycle numbering: acceptance cycle = T0. Illegal request response: resp_valid in T1.
- Word-aligned RAM address = {req_addr[31:2], 2'b00}. Lane = addr[1:0] for bytes, addr[1] for halves.
- Load sequence:
  - RD: mem_r_en=1 in T1.
  - RD_WAIT: mem_r_data and mem_state sampled in T2.
  - RESP: resp_valid in T3. Latency is 3 cycles.
  - Extraction: byte lane k = data[8k+7:8k]; half lane h = data[16h+15:16h]; then extend per req_unsigned.
- Word store sequence:
  - WR: mem_w_en=1 with mem_w_data=req_wdata in T1.
  - WR_WAIT: mem_state sampled in T2.
  - RESP: resp_valid in T3.
- Sub-word store (RMW) sequence:
  - RMW_RD: mem_r_en in T1.
  - RMW_WAIT: sample in T2 and merge the store bytes into the read word.
  - RMW_WR: mem_w_en in T3 with the merged word.
  - WR_WAIT: sample state in T4.
  - RESP: resp_valid in T5.
  - If mem_state≠00 in T2: abort, no write, RESP in T3 carrying that code.
- Errors:
  - resp_err=1 whenever resp_code≠00.
  - resp_rdata=0 on error and for all stores.
  - mem_state is sampled only in wait states; stale values at other times are ignored.
- Strobe rules:
  - mem_r_en and mem_w_en are never high in the same cycle, so code 01 cannot originate here; it is forwarded if the RAM reports it anyway.
  - Each strobe is high for exactly one cycle per access.
  - Address/data outputs hold their values while the corresponding enable is high and are 0 otherwise.
- RESP lasts one cycle, then IDLE. Back-to-back loads can be accepted every 4 cycles.

Test Plan:
- RAM word0=0x8081_8283. Load byte, signed, addr 0x1 -> mem_r_en T1 with addr 0x0; resp T3 rdata=0xFFFF_FF82, code 00.
- Same word. Load half, unsigned, addr 0x2 -> rdata=0x0000_8081. Load half, signed, addr 0x2 -> rdata=0xFFFF_8081.
- Store byte 0xAB to addr 0x6, RAM word1=0x1122_3344:
  - mem_r_en T1; mem_w_en T3 with w_addr 0x4 and data 0x11AB_3344; resp T5 code 00;
  - a following word load of 0x4 returns 0x11AB_3344.
- Load word addr 0x2 -> resp T1, code 11, no mem strobes. Load half addr 0x3 -> same.
- Word load at addr 4*MEMORY_SIZE_WORDS -> RAM reports 10; resp code 10, rdata 0.
- Same store byte to an out-of-bounds address -> RMW read errors, no mem_w_en ever.
- Assert rst in T2 of an RMW store -> outputs 0 immediately, no mem_w_en, RAM word unchanged, req_ready=1 after release.
